// File: rtl/drive_command_arbiter.sv
// ---------------------------------------------------------------------------
// drive_command_arbiter
//
// Merges drive requests from the camera tracker and the microphone/FFT
// direction logic into one direction/speed command for drive_motor.
//   - Fixed priority: camera over microphone. A new owner keeps the grant for
//     at least HOLD_CYCLES clocks before a higher-priority requester may take
//     it. A lower-priority requester never preempts.
//   - Speed moves by one step every RAMP_CYCLES clocks. It always ramps to 0
//     before the direction is reversed or changed.
//   - An ultrasonic sample below TOO_CLOSE stops the drive at once and
//     latches the obstacle flag. The flag clears only on a sample at or above
//     TOO_CLOSE + HYST.
//
// Optional feature (compile-time macro ARB_WATCHDOG_EN):
//   When defined, WDOG_CYCLES clocks without any distance_valid strobe is
//   treated as an obstacle (fail-safe). When undefined, there is no
//   watchdog and the last obstacle decision persists.
//
// Ports
//   clk             in  1  system clock (50 MHz)
//   reset           in  1  synchronous, active-high
//   distance        in  8  ultrasonic distance, qualified by distance_valid
//   distance_valid  in  1  one-cycle sample strobe
//   cam_req         in  1  camera requester active
//   cam_direction   in  3  camera requested direction
//   cam_speed       in  3  camera requested speed
//   mic_req         in  1  microphone requester active
//   mic_direction   in  3  microphone requested direction
//   mic_speed       in  3  microphone requested speed
//   direction       out 3  0 STOP, 1 FWD, 2 REV, 3 LEFT, 4 RIGHT (5-7 = STOP)
//   speed           out 3  command speed 0..7
//   grant           out 2  0 none, 1 camera, 2 microphone
//   obstacle        out 1  safety stop latched
//   cmd_update      out 1  pulses in the cycle direction or speed changes
// ---------------------------------------------------------------------------
module drive_command_arbiter #(
    parameter logic [7:0] TOO_CLOSE   = 8'd20,
    parameter logic [7:0] HYST        = 8'd4,
    parameter int         HOLD_CYCLES = 5_000_000,
    parameter int         RAMP_CYCLES = 2_500_000,
    parameter int         WDOG_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] distance,
    input  logic       distance_valid,
    input  logic       cam_req,
    input  logic [2:0] cam_direction,
    input  logic [2:0] cam_speed,
    input  logic       mic_req,
    input  logic [2:0] mic_direction,
    input  logic [2:0] mic_speed,
    output logic [2:0] direction,
    output logic [2:0] speed,
    output logic [1:0] grant,
    output logic       obstacle,
    output logic       cmd_update
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int RAMP_W = $clog2(RAMP_CYCLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);

    localparam logic [2:0] DIR_STOP  = 3'd0;
    localparam logic [2:0] DIR_FWD   = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    localparam logic [1:0] GR_NONE = 2'd0;
    localparam logic [1:0] GR_CAM  = 2'd1;
    localparam logic [1:0] GR_MIC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_OWN       = 2'd1,
        ST_RAMP_DOWN = 2'd2,
        ST_OBSTACLE  = 2'd3
    } state_t;

    // One ramp step toward the target speed, taken only on a ramp tick.
    function automatic logic [2:0] ramp_step(input logic [2:0] cur,
                                             input logic [2:0] tgt,
                                             input logic       tick);
        logic [2:0] nxt;
        nxt = cur;
        if (tick) begin
            if (cur < tgt)
                nxt = cur + 3'd1;
            else if (cur > tgt)
                nxt = cur - 3'd1;
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [2:0]        r_dir;
    logic [2:0]        r_speed;
    logic [1:0]        r_grant;
    logic              r_obstacle;
    logic              r_cmd_update;
    logic [HOLD_W-1:0] r_hold;
    logic [RAMP_W-1:0] r_tick_cnt;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic              w_tick;
    logic              w_too_close;
    logic              w_clear;
    logic              w_wdog_trip;
    logic              w_enter_obs;
    logic              w_own_req;
    logic [2:0]        w_own_dir;
    logic [2:0]        w_own_spd;
    logic              w_tgt_legal;
    logic [2:0]        w_tgt_dir;
    logic [2:0]        w_tgt_spd;
    logic [2:0]        w_dn_spd;
    logic [2:0]        w_idle_dir;
    logic [2:0]        w_step_spd;
    logic [1:0]        w_grant_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_release;
    state_t            w_state_nxt;
    logic [2:0]        w_dir_nxt;
    logic [2:0]        w_spd_nxt;
    logic              w_upd_nxt;

    assign w_tick = (r_tick_cnt == RAMP_LAST);

    // The clear threshold is formed in 9 bits so TOO_CLOSE + HYST never wraps.
    assign w_too_close = distance_valid && (distance < TOO_CLOSE);
    assign w_clear     = distance_valid &&
                         ({1'b0, distance} >= ({1'b0, TOO_CLOSE} + {1'b0, HYST}));

`ifdef ARB_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);

    logic [WDOG_W-1:0] r_wdog;

    // Saturating count of clocks since the last distance sample.
    always_ff @(posedge clk) begin
        if (reset)
            r_wdog <= '0;
        else if (distance_valid)
            r_wdog <= '0;
        else if (r_wdog != WDOG_LIMIT)
            r_wdog <= r_wdog + WDOG_W'(1);
    end

    // A sample arriving in the expiry cycle counts as sensor activity.
    assign w_wdog_trip = (r_wdog == WDOG_LIMIT) && !distance_valid;
`else
    // No watchdog: never trips (the parameter is still referenced so the
    // interface stays identical between builds).
    assign w_wdog_trip = (WDOG_CYCLES < 0);
`endif

    assign w_enter_obs = w_too_close || w_wdog_trip;

    // Current owner's request, taken from the registered grant.
    always_comb begin
        w_own_req = 1'b0;
        w_own_dir = DIR_STOP;
        w_own_spd = 3'd0;
        case (r_grant)
            GR_CAM: begin
                w_own_req = cam_req;
                w_own_dir = cam_direction;
                w_own_spd = cam_speed;
            end
            GR_MIC: begin
                w_own_req = mic_req;
                w_own_dir = mic_direction;
                w_own_spd = mic_speed;
            end
            default: ;
        endcase
    end

    // Illegal direction codes, an explicit STOP, or speed 0 all mean STOP/0.
    assign w_tgt_legal = (w_own_dir >= DIR_FWD) && (w_own_dir <= DIR_RIGHT) &&
                         (w_own_spd != 3'd0);
    assign w_tgt_dir   = w_tgt_legal ? w_own_dir : DIR_STOP;
    assign w_tgt_spd   = w_tgt_legal ? w_own_spd : 3'd0;

    // Ramp-down step, and the direction used while winding down to STOP.
    assign w_dn_spd   = (w_tick && (r_speed != 3'd0)) ? (r_speed - 3'd1) : r_speed;
    assign w_idle_dir = (r_speed == 3'd0) ? DIR_STOP : r_dir;
    assign w_step_spd = ramp_step(r_speed, w_tgt_spd, w_tick);

    // ------------------------------------------------------------------
    // Arbitration: grant owner and hold counter
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_nxt = r_grant;
        w_hold_nxt  = (r_hold != '0) ? (r_hold - HOLD_W'(1)) : '0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_hold_nxt = '0;
                if (cam_req) begin
                    w_grant_nxt = GR_CAM;
                    w_hold_nxt  = HOLD_LOAD;
                end else if (mic_req) begin
                    w_grant_nxt = GR_MIC;
                    w_hold_nxt  = HOLD_LOAD;
                end
            end
            ST_OWN, ST_RAMP_DOWN: begin
                if (!w_own_req) begin
                    // Owner dropped: release at once, ignoring the hold time.
                    // The owner's own req is low, so cam_req here means the
                    // owner was the microphone.
                    if (cam_req) begin
                        w_grant_nxt = GR_CAM;
                        w_hold_nxt  = HOLD_LOAD;
                    end else if (mic_req) begin
                        w_grant_nxt = GR_MIC;
                        w_hold_nxt  = HOLD_LOAD;
                    end else begin
                        w_grant_nxt = GR_NONE;
                        w_hold_nxt  = '0;
                        w_release   = 1'b1;
                    end
                end else if ((r_grant == GR_MIC) && cam_req && (r_hold == '0)) begin
                    w_grant_nxt = GR_CAM;
                    w_hold_nxt  = HOLD_LOAD;
                end
            end
            default: begin
                w_grant_nxt = GR_NONE;
                w_hold_nxt  = '0;
            end
        endcase
        if (w_enter_obs) begin
            w_grant_nxt = GR_NONE;
            w_hold_nxt  = '0;
        end
    end

    // ------------------------------------------------------------------
    // Motion: state, direction and speed
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_spd_nxt   = r_speed;
        case (r_state)
            ST_IDLE: begin
                w_dir_nxt = w_idle_dir;
                w_spd_nxt = w_dn_spd;
                if (w_grant_nxt != GR_NONE)
                    w_state_nxt = ST_OWN;
            end
            ST_OWN: begin
                if (w_release) begin
                    w_dir_nxt   = w_idle_dir;
                    w_spd_nxt   = w_dn_spd;
                    w_state_nxt = ST_IDLE;
                end else if (w_tgt_dir != r_dir) begin
                    if (r_speed != 3'd0) begin
                        w_spd_nxt   = w_dn_spd;
                        w_state_nxt = ST_RAMP_DOWN;
                    end else begin
                        w_dir_nxt = w_tgt_dir;
                    end
                end else begin
                    w_spd_nxt = w_step_spd;
                end
            end
            ST_RAMP_DOWN: begin
                if (w_release) begin
                    w_dir_nxt   = w_idle_dir;
                    w_spd_nxt   = w_dn_spd;
                    w_state_nxt = ST_IDLE;
                end else if (r_speed == 3'd0) begin
                    // Fully stopped: take the new heading, then ramp up in OWN.
                    w_dir_nxt   = w_tgt_dir;
                    w_state_nxt = ST_OWN;
                end else begin
                    w_spd_nxt = w_dn_spd;
                end
            end
            default: begin
                w_dir_nxt = DIR_STOP;
                w_spd_nxt = 3'd0;
                if (w_clear)
                    w_state_nxt = ST_IDLE;
            end
        endcase
        // Obstacle entry overrides every other transition and skips the ramp.
        if (w_enter_obs) begin
            w_state_nxt = ST_OBSTACLE;
            w_dir_nxt   = DIR_STOP;
            w_spd_nxt   = 3'd0;
        end
    end

    assign w_upd_nxt = (w_dir_nxt != r_dir) || (w_spd_nxt != r_speed);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_dir        <= DIR_STOP;
            r_speed      <= 3'd0;
            r_grant      <= GR_NONE;
            r_obstacle   <= 1'b0;
            r_cmd_update <= 1'b0;
            r_hold       <= '0;
            r_tick_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_dir        <= w_dir_nxt;
            r_speed      <= w_spd_nxt;
            r_grant      <= w_grant_nxt;
            r_obstacle   <= (w_state_nxt == ST_OBSTACLE);
            r_cmd_update <= w_upd_nxt;
            r_hold       <= w_hold_nxt;
            r_tick_cnt   <= w_tick ? '0 : (r_tick_cnt + RAMP_W'(1));
        end
    end

    assign direction  = r_dir;
    assign speed      = r_speed;
    assign grant      = r_grant;
    assign obstacle   = r_obstacle;
    assign cmd_update = r_cmd_update;

endmodule

// File: tb/tb_drive_command_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for drive_command_arbiter with HOLD_CYCLES=8, RAMP_CYCLES=4,
// WDOG_CYCLES=64. Edges are counted from the first rising edge after reset
// is released (E1, E2, ...). Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_drive_command_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] distance = 8'd100;
    logic       distance_valid = 1'b0;
    logic       cam_req = 1'b0;
    logic [2:0] cam_direction = 3'd0;
    logic [2:0] cam_speed = 3'd0;
    logic       mic_req = 1'b0;
    logic [2:0] mic_direction = 3'd0;
    logic [2:0] mic_speed = 3'd0;
    logic [2:0] direction;
    logic [2:0] speed;
    logic [1:0] grant;
    logic       obstacle;
    logic       cmd_update;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    always #5 clk = ~clk;

    drive_command_arbiter #(
        .TOO_CLOSE  (8'd20),
        .HYST       (8'd4),
        .HOLD_CYCLES(8),
        .RAMP_CYCLES(4),
        .WDOG_CYCLES(64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .distance      (distance),
        .distance_valid(distance_valid),
        .cam_req       (cam_req),
        .cam_direction (cam_direction),
        .cam_speed     (cam_speed),
        .mic_req       (mic_req),
        .mic_direction (mic_direction),
        .mic_speed     (mic_speed),
        .direction     (direction),
        .speed         (speed),
        .grant         (grant),
        .obstacle      (obstacle),
        .cmd_update    (cmd_update)
    );

    typedef struct {
        logic       rst;
        logic       mreq;
        logic [2:0] mdir;
        logic [2:0] mspd;
        logic [2:0] edir;
        logic [2:0] espd;
        logic [1:0] egr;
        logic       eobs;
        logic       eupd;
    } vec_t;

    vec_t tv[15];

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic run_to(input int n);
        while (ecnt < n) step();
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [2:0] ed, input logic [2:0] es,
                           input logic [1:0] eg, input logic eo, input logic eu);
        chk({name, ".dir"},  {5'b0, direction},  {5'b0, ed});
        chk({name, ".spd"},  {5'b0, speed},      {5'b0, es});
        chk({name, ".gnt"},  {6'b0, grant},      {6'b0, eg});
        chk({name, ".obs"},  {7'b0, obstacle},   {7'b0, eo});
        chk({name, ".upd"},  {7'b0, cmd_update}, {7'b0, eu});
    endtask

    task automatic clear_inputs();
        cam_req = 1'b0; cam_direction = 3'd0; cam_speed = 3'd0;
        mic_req = 1'b0; mic_direction = 3'd0; mic_speed = 3'd0;
        distance_valid = 1'b0; distance = 8'd100;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        ecnt = 0;
    endtask

    task automatic sample(input logic [7:0] d);
        distance = d;
        distance_valid = 1'b1;
        step();
        distance_valid = 1'b0;
    endtask

    initial begin
        logic exp_wd;

        // ---- Test 1: reset, then mic FWD/3 ramp-up (table driven) ----
        //            rst   mreq  mdir  mspd  edir  espd  egr   eobs  eupd
        tv[0]  = '{1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 3'd1, 3'd3, 3'd0, 3'd0, 2'd2, 1'b0, 1'b0}; // E1 grant
        tv[3]  = '{1'b0, 1'b1, 3'd1, 3'd3, 3'd1, 3'd0, 2'd2, 1'b0, 1'b1}; // E2 dir
        tv[4]  = '{1'b0, 1'b1, 3'd1, 3'd3, 3'd1, 3'd0, 2'd2, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 3'd1, 3'd3, 3'd1, 3'd1, 2'd2, 1'b0, 1'b1}; // E4 tick
        tv[6]  = '{1'b0, 1'b1, 3'd1, 3'd3, 3'd1, 3'd1, 2'd2, 1'b0, 1'b0};
        tv[7]  = '{1'b0, 1'b1, 3'd1, 3'd3, 3'd1, 3'd1, 2'd2, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 3'd1, 3'd3, 3'd1, 3'd1, 2'd2, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 3'd1, 3'd3, 3'd1, 3'd2, 2'd2, 1'b0, 1'b1}; // E8 tick
        tv[10] = '{1'b0, 1'b1, 3'd1, 3'd3, 3'd1, 3'd2, 2'd2, 1'b0, 1'b0};
        tv[11] = '{1'b0, 1'b1, 3'd1, 3'd3, 3'd1, 3'd2, 2'd2, 1'b0, 1'b0};
        tv[12] = '{1'b0, 1'b1, 3'd1, 3'd3, 3'd1, 3'd2, 2'd2, 1'b0, 1'b0};
        tv[13] = '{1'b0, 1'b1, 3'd1, 3'd3, 3'd1, 3'd3, 2'd2, 1'b0, 1'b1}; // E12 tick
        tv[14] = '{1'b0, 1'b1, 3'd1, 3'd3, 3'd1, 3'd3, 2'd2, 1'b0, 1'b0};

        clear_inputs();
        for (int i = 0; i < 15; i++) begin
            reset         = tv[i].rst;
            mic_req       = tv[i].mreq;
            mic_direction = tv[i].mdir;
            mic_speed     = tv[i].mspd;
            step();
            chk_out($sformatf("t1[%0d]", i), tv[i].edir, tv[i].espd, tv[i].egr,
                    tv[i].eobs, tv[i].eupd);
        end
        reset = 1'b0;

        // ---- Test 2: hold time blocks preemption, then reversal via ramp-down ----
        do_reset();
        mic_req = 1'b1; mic_direction = 3'd1; mic_speed = 3'd3;
        run_to(2);
        cam_req = 1'b1; cam_direction = 3'd2; cam_speed = 3'd2;
        run_to(5);
        chk("t2.hold_e5.gnt", {6'b0, grant}, 8'd2);
        run_to(8);
        chk_out("t2.e8", 3'd1, 3'd2, 2'd2, 1'b0, 1'b1);
        run_to(9);
        chk("t2.preempt.gnt", {6'b0, grant}, 8'd1);
        run_to(12);
        chk_out("t2.e12", 3'd1, 3'd1, 2'd1, 1'b0, 1'b1);
        run_to(16);
        chk_out("t2.e16", 3'd1, 3'd0, 2'd1, 1'b0, 1'b1);
        run_to(17);
        chk_out("t2.e17", 3'd2, 3'd0, 2'd1, 1'b0, 1'b1);
        run_to(20);
        chk("t2.e20.spd", {5'b0, speed}, 8'd1);
        run_to(24);
        chk("t2.e24.spd", {5'b0, speed}, 8'd2);
        run_to(28);
        chk_out("t2.e28", 3'd2, 3'd2, 2'd1, 1'b0, 1'b0);

        // ---- Test 3: obstacle entry, requests ignored, hysteresis clear ----
        do_reset();
        cam_req = 1'b1; cam_direction = 3'd1; cam_speed = 3'd5;
        run_to(8);
        chk_out("t3.e8", 3'd1, 3'd2, 2'd1, 1'b0, 1'b1);
        sample(8'd20);                              // E9: at threshold, not close
        chk("t3.at20.obs", {7'b0, obstacle}, 8'd0);
        chk("t3.at20.spd", {5'b0, speed}, 8'd2);
        sample(8'd15);                              // E10
        chk_out("t3.enter", 3'd0, 3'd0, 2'd0, 1'b1, 1'b1);
        run_to(13);
        chk_out("t3.ignore", 3'd0, 3'd0, 2'd0, 1'b1, 1'b0);
        sample(8'd22);                              // E14
        chk("t3.s22.obs", {7'b0, obstacle}, 8'd1);
        sample(8'd23);                              // E15
        chk("t3.s23.obs", {7'b0, obstacle}, 8'd1);
        sample(8'd24);                              // E16
        chk_out("t3.clear", 3'd0, 3'd0, 2'd0, 1'b0, 1'b0);
        step();                                     // E17
        chk("t3.regrant.gnt", {6'b0, grant}, 8'd1);
        step();                                     // E18
        chk("t3.regrant.dir", {5'b0, direction}, 8'd1);

        // ---- Test 4: owner drop releases immediately, then to IDLE ----
        do_reset();
        cam_req = 1'b1; cam_direction = 3'd1; cam_speed = 3'd5;
        mic_req = 1'b1; mic_direction = 3'd1; mic_speed = 3'd2;
        step();
        chk("t4.e1.gnt", {6'b0, grant}, 8'd1);
        step();
        chk("t4.e2.gnt", {6'b0, grant}, 8'd1);
        chk("t4.e2.dir", {5'b0, direction}, 8'd1);
        cam_req = 1'b0;
        step();
        chk("t4.drop.gnt", {6'b0, grant}, 8'd2);
        mic_req = 1'b0;
        step();
        chk_out("t4.idle", 3'd0, 3'd0, 2'd0, 1'b0, 1'b1);

        // ---- Test 5: clear with 255, then reset mid ramp-down ----
        do_reset();
        sample(8'd19);                              // E1
        chk("t5.s19.obs", {7'b0, obstacle}, 8'd1);
        sample(8'd255);                             // E2
        chk("t5.s255.obs", {7'b0, obstacle}, 8'd0);
        cam_req = 1'b1; cam_direction = 3'd1; cam_speed = 3'd5;
        run_to(12);
        chk_out("t5.e12", 3'd1, 3'd2, 2'd1, 1'b0, 1'b1);
        cam_direction = 3'd2;
        run_to(16);
        chk_out("t5.rampdn", 3'd1, 3'd1, 2'd1, 1'b0, 1'b1);
        reset = 1'b1;
        step();
        chk_out("t5.reset", 3'd0, 3'd0, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        cam_req = 1'b0;
        step(); step(); step(); step();
        chk_out("t5.after", 3'd0, 3'd0, 2'd0, 1'b0, 1'b0);

        // ---- Test 6: no distance samples for more than WDOG_CYCLES ----
        do_reset();
`ifdef ARB_WATCHDOG_EN
        exp_wd = 1'b1;
`else
        exp_wd = 1'b0;
`endif
        run_to(70);
        chk("t6.wdog.obs", {7'b0, obstacle}, {7'b0, exp_wd});
        chk("t6.wdog.spd", {5'b0, speed}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
